seal_tx: RTL and testbench

Transmit-side framing block for the cipher datapath. It accepts a stream of plaintext bytes grouped into frames, encrypts each byte with the existing `encrypt` module, and forwards the ciphertext. It folds each ciphertext byte through the existing key-based `hash` module into a running frame tag, then appends that tag as one trailing byte after the last data byte. Its output is exactly what the receive-side `verify` path consumes: ciphertext bytes plus a reference hash.

---
 rtl/seal_pkg.sv | 28 ++
 rtl/encrypt.sv | 24 ++
 rtl/hash.sv | 22 ++
 rtl/seal_tag_acc.sv | 71 +++++++
 rtl/seal_tx.sv | 145 ++++++++++++++
 tb/tb_seal_tx.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/seal_pkg.sv
// -----------------------------------------------------------------------------
// seal_pkg
//   Shared definitions for the transmit-side sealing datapath.
//   - seal_state_t     : framing FSM states (accepting data / tag pending)
//   - TAG_SEED_DEFAULT : reset / start-of-frame value of the tag accumulator
//   - MAX_LEN_DEFAULT  : default maximum data bytes per frame
//   - ENC_* / HASH_KEY : keys used by the encrypt and hash primitives
//   - rotl1()          : 8-bit rotate left by one
// -----------------------------------------------------------------------------
package seal_pkg;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_TAG  = 1'b1
    } seal_state_t;

    localparam logic [7:0]  TAG_SEED_DEFAULT = 8'hA5;
    localparam int unsigned MAX_LEN_DEFAULT  = 16;

    localparam logic [7:0]  ENC_KEY  = 8'h6B;
    localparam logic [7:0]  ENC_BIAS = 8'h1D;
    localparam logic [7:0]  HASH_KEY = 8'hC3;

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/encrypt.sv
// -----------------------------------------------------------------------------
// encrypt
//   Combinational byte cipher: whiten with KEY, rotate left by 3, add BIAS
//   (mod 256).
//   Ports:
//     pt_i : plaintext byte
//     ct_o : ciphertext byte
// -----------------------------------------------------------------------------
module encrypt #(
    parameter logic [7:0] KEY  = 8'h6B,
    parameter logic [7:0] BIAS = 8'h1D
) (
    input  logic [7:0] pt_i,
    output logic [7:0] ct_o
);

    logic [7:0] whitened;

    always_comb begin
        whitened = pt_i ^ KEY;
        ct_o     = {whitened[4:0], whitened[7:5]} + BIAS;
    end

endmodule

// File: rtl/hash.sv
// -----------------------------------------------------------------------------
// hash
//   Combinational key-based byte hash used to fold ciphertext into the tag.
//   Ports:
//     data_i : byte to hash
//     hash_o : hashed byte
// -----------------------------------------------------------------------------
module hash #(
    parameter logic [7:0] KEY = 8'hC3
) (
    input  logic [7:0] data_i,
    output logic [7:0] hash_o
);

    logic [7:0] keyed;

    always_comb begin
        keyed  = data_i ^ KEY;
        hash_o = keyed ^ {keyed[5:0], keyed[7:6]} ^ {3'b000, keyed[7:3]};
    end

endmodule

// File: rtl/seal_tag_acc.sv
// -----------------------------------------------------------------------------
// seal_tag_acc
//   Encrypts the incoming plaintext byte and maintains the running frame tag:
//   acc <= rotl1(acc) ^ hash(encrypt(pt)) on every accepted byte, and acc is
//   reseeded when the tag is loaded into the output register.
//   Ports:
//     clk       : clock
//     rst       : synchronous active-high reset (acc -> TAG_SEED)
//     pt_i      : plaintext byte
//     accept_i  : pt_i is accepted this cycle, fold its ciphertext into acc
//     clear_i   : tag is being emitted this cycle, reseed acc
//     ct_o      : encrypt(pt_i), combinational
//     acc_o     : current accumulator value (tag of the bytes so far)
// -----------------------------------------------------------------------------
module seal_tag_acc
    import seal_pkg::*;
#(
    parameter logic [7:0] TAG_SEED = TAG_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pt_i,
    input  logic       accept_i,
    input  logic       clear_i,
    output logic [7:0] ct_o,
    output logic [7:0] acc_o
);

    logic [7:0] ct;
    logic [7:0] ct_hash;
    logic [7:0] acc_q;
    logic [7:0] acc_d;

    encrypt #(
        .KEY  (ENC_KEY),
        .BIAS (ENC_BIAS)
    ) u_encrypt (
        .pt_i (pt_i),
        .ct_o (ct)
    );

    hash #(
        .KEY (HASH_KEY)
    ) u_hash (
        .data_i (ct),
        .hash_o (ct_hash)
    );

    // Clear and accept are mutually exclusive (no input is taken while the
    // tag is pending); clear is given priority for robustness.
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = TAG_SEED;
        end else if (accept_i) begin
            acc_d = rotl1(acc_q) ^ ct_hash;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= TAG_SEED;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign ct_o  = ct;
    assign acc_o = acc_q;

endmodule

// File: rtl/seal_tx.sv
// -----------------------------------------------------------------------------
// seal_tx
//   Transmit framing: encrypts plaintext bytes, forwards the ciphertext through
//   a single-entry output register and appends one tag byte per frame. Frames
//   longer than MAX_LEN bytes are force-terminated (trunc pulse).
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : plaintext handshake
//     in_data, in_last    : plaintext byte, end-of-frame marker
//     out_valid/out_ready : output handshake
//     out_data            : ciphertext or tag byte
//     out_is_tag          : out_data is the frame tag
//     out_last            : final byte of the frame (always the tag)
//     frame_cnt           : completed frames (tag handshakes), wrapping
//     trunc               : one-cycle pulse after a forced frame termination
// -----------------------------------------------------------------------------
module seal_tx
    import seal_pkg::*;
#(
    parameter logic [7:0]  TAG_SEED = TAG_SEED_DEFAULT,
    parameter int unsigned MAX_LEN  = MAX_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_is_tag,
    output logic        out_last,
    output logic [15:0] frame_cnt,
    output logic        trunc
);

    localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);

    seal_state_t state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_is_tag_q, out_is_tag_d;
    logic        out_last_q, out_last_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;

    logic        slot_free;
    logic        accept;
    logic        tag_load;
    logic        at_max;
    logic        out_hs;
    logic [7:0]  ct;
    logic [7:0]  acc;

    // The output register may be refilled in the same cycle it is drained.
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_DATA) && slot_free && !rst;
    assign accept    = in_valid && in_ready;
    assign tag_load  = (state_q == S_TAG) && slot_free;
    assign at_max    = (byte_cnt_q == LAST_IDX);
    assign out_hs    = out_valid_q && out_ready;

    seal_tag_acc #(
        .TAG_SEED (TAG_SEED)
    ) u_tag_acc (
        .clk      (clk),
        .rst      (rst),
        .pt_i     (in_data),
        .accept_i (accept),
        .clear_i  (tag_load),
        .ct_o     (ct),
        .acc_o    (acc)
    );

    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_is_tag_d = out_is_tag_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        frame_cnt_d  = frame_cnt_q;
        trunc_d      = 1'b0;
        byte_cnt_d   = byte_cnt_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end

        if (accept) begin
            out_data_d   = ct;
            out_is_tag_d = 1'b0;
            out_last_d   = 1'b0;
            out_valid_d  = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            if (in_last || at_max) begin
                state_d = S_TAG;
            end
            trunc_d = at_max && !in_last;
        end else if (tag_load) begin
            // acc already includes the last data byte: it was folded on the
            // accept edge, one cycle before the earliest possible tag load.
            out_data_d   = acc;
            out_is_tag_d = 1'b1;
            out_last_d   = 1'b1;
            out_valid_d  = 1'b1;
            byte_cnt_d   = '0;
            state_d      = S_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_DATA;
            out_data_q   <= '0;
            out_is_tag_q <= 1'b0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_cnt_q  <= '0;
            trunc_q      <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_is_tag_q <= out_is_tag_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            frame_cnt_q  <= frame_cnt_d;
            trunc_q      <= trunc_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_is_tag = out_is_tag_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign frame_cnt  = frame_cnt_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_seal_tx.sv
// -----------------------------------------------------------------------------
// tb_seal_tx
//   Scoreboard bench for seal_tx: expected output bytes are queued when an
//   input byte is accepted and compared when the DUT presents output.
// -----------------------------------------------------------------------------
module tb_seal_tx;

    localparam logic [7:0] SEED = 8'hA5;
    localparam int         MAXL = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       t;
        logic       l;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_is_tag;
    logic        out_last;
    logic [15:0] frame_cnt;
    logic        trunc;

    seal_tx #(
        .TAG_SEED (SEED),
        .MAX_LEN  (MAXL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_is_tag (out_is_tag),
        .out_last   (out_last),
        .frame_cnt  (frame_cnt),
        .trunc      (trunc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_enc(input logic [7:0] p);
        logic [7:0] x;
        x = p ^ 8'h6B;
        return {x[4:0], x[7:5]} + 8'h1D;
    endfunction

    function automatic logic [7:0] m_hash(input logic [7:0] d);
        logic [7:0] y;
        y = d ^ 8'hC3;
        return y ^ {y[5:0], y[7:6]} ^ {3'b000, y[7:3]};
    endfunction

    function automatic logic [7:0] m_rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    item_t       sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          bp = 1'b0;
    bit          accepted;
    bit          lat_pend = 1'b0;
    bit          exp_trunc = 1'b0;
    int          n_trunc = 0;
    logic [7:0]  m_acc = SEED;
    int          m_cnt = 0;
    logic [15:0] m_fc = '0;
    logic [7:0]  last_tag_seen = '0;
    logic [7:0]  last_tag_exp = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: inputs are already driven (we are at a negedge).
    task automatic tick();
        item_t it;
        bit    forced;
        if (bp) out_ready = 1'($urandom_range(0, 1));
        #1;
        accepted = 1'b0;
        if (!rst) begin
            chk("frame_cnt", frame_cnt, m_fc);
            chk("trunc", trunc, exp_trunc);
            if (trunc) n_trunc++;
            exp_trunc = 1'b0;
            if (lat_pend) begin
                chk("latency_valid", out_valid, 1);
                lat_pend = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    chk("out_data", out_data, sb[0].d);
                    chk("out_is_tag", out_is_tag, sb[0].t);
                    chk("out_last", out_last, sb[0].l);
                    if (out_ready) begin
                        it = sb.pop_front();
                        if (it.l) m_fc = m_fc + 16'd1;
                        if (out_is_tag) last_tag_seen = out_data;
                    end
                end
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                lat_pend = 1'b1;
                it.d = m_enc(in_data);
                it.t = 1'b0;
                it.l = 1'b0;
                sb.push_back(it);
                forced = (m_cnt == MAXL - 1);
                m_acc  = m_rotl(m_acc) ^ m_hash(it.d);
                m_cnt++;
                if (in_last || forced) begin
                    it.d = m_acc;
                    it.t = 1'b1;
                    it.l = 1'b1;
                    sb.push_back(it);
                    last_tag_exp = m_acc;
                    m_acc = SEED;
                    m_cnt = 0;
                end
                if (forced && !in_last) exp_trunc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        tick();
        while (!accepted && waits < 100) begin
            waits++;
            tick();
        end
        chk("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_is_tag", out_is_tag, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_in_ready", in_ready, 0);
        sb.delete();
        m_acc     = SEED;
        m_cnt     = 0;
        m_fc      = '0;
        exp_trunc = 1'b0;
        lat_pend  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Frames back to back with in_valid held high: exactly one stall per frame.
    task automatic b2b_frames(input int nfr);
        int w;
        int len;
        for (int f = 0; f < nfr; f++) begin
            len = (f % 3) + 1;
            for (int b = 0; b < len; b++) begin
                send_byte(8'($urandom), (b == len - 1), w);
                chk("b2b_idle", w, (b == 0 && f > 0) ? 1 : 0);
            end
        end
        drain();
    endtask

    initial begin
        int w;
        int len;
        logic [7:0] t1_tag;

        do_reset();

        // Single frame 01 02 03
        send_byte(8'h01, 1'b0, w);
        send_byte(8'h02, 1'b0, w);
        send_byte(8'h03, 1'b1, w);
        drain();
        chk("t1_frame_cnt", frame_cnt, 16'd1);
        chk("t1_tag", last_tag_seen, last_tag_exp);
        t1_tag = last_tag_exp;

        // One-byte frame, then the next frame's first byte sees one stall
        send_byte(8'h00, 1'b1, w);
        chk("t2_tag_model", last_tag_exp, m_rotl(SEED) ^ m_hash(m_enc(8'h00)));
        send_byte(8'h5A, 1'b1, w);
        chk("t2_idle", w, 1);
        drain();
        chk("t2_frame_cnt", frame_cnt, 16'd3);

        // Backpressure, 10 random frames
        do_reset();
        bp = 1'b1;
        for (int f = 0; f < 10; f++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) send_byte(8'($urandom), (b == len - 1), w);
        end
        drain();
        bp = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_frame_cnt", frame_cnt, 16'd10);

        // Overlong frame: 20 bytes without in_last, then close the 2nd frame
        n_trunc = 0;
        for (int b = 0; b < 20; b++) send_byte(8'(b + 8'h30), 1'b0, w);
        send_byte(8'hEE, 1'b1, w);
        drain();
        chk("trunc_pulses", n_trunc, 1);
        chk("ovl_frame_cnt", frame_cnt, 16'd12);

        // Reset mid-frame
        send_byte(8'h11, 1'b0, w);
        send_byte(8'h22, 1'b0, w);
        do_reset();
        tick();
        chk("post_rst_frame_cnt", frame_cnt, 16'd0);
        chk("post_rst_valid", out_valid, 0);
        send_byte(8'h01, 1'b0, w);
        send_byte(8'h02, 1'b0, w);
        send_byte(8'h03, 1'b1, w);
        drain();
        chk("fresh_tag", last_tag_seen, t1_tag);
        chk("fresh_frame_cnt", frame_cnt, 16'd1);

        // Back-to-back frames
        b2b_frames(4);
        chk("b2b_frame_cnt", frame_cnt, 16'd5);

        // frame_cnt wrap from a preset near 16'hFFFF
        force dut.frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt_q;
        m_fc = 16'hFFFE;
        b2b_frames(3);
        chk("wrap_frame_cnt", frame_cnt, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
